// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO peripheral: frame field codes,
// bit-index landmarks within a 32-bit frame, and the decoder state type.
package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Bit indices count rising MDC edges, starting at 1 for the first ST bit
    localparam logic [5:0] HDR_END   = 6'd14;
    localparam logic [5:0] TA_END    = 6'd16;
    localparam logic [5:0] FRAME_END = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WR,
        RD,
        SKIP
    } mdio_state_t;

    // Header is {ST, OP, PHYAD, REGAD}; valid means ST is 01 and OP is read or write
    function automatic logic header_valid(input logic [13:0] hdr);
        return (hdr[13:12] == ST_CODE) &&
               ((hdr[11:10] == OP_WRITE) || (hdr[11:10] == OP_READ));
    endfunction

endpackage

// File: rtl/mdc_edge_det.sv
// MDC edge detector: registers MDC once in the clk domain and flags the
// cycle in which a rising or falling transition is first visible.
module mdc_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    output logic rise,
    output logic fall
);

    logic mdc_q;

    // One-stage history of MDC; MDC is generated in this clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc;
        end
    end

    assign rise = mdc & ~mdc_q;
    assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO peripheral (PHY side). Decodes 32-bit management frames
// from the controller's MDC/MDIO_OUT/MDIO_OE, performs register writes and
// reads through a 32x16 memory port, and serialises read data on MDIO_IN.
// Optional feature macro: MDIO_PHYAD_FILTER_EN -- when defined, frames whose
// PHYAD differs from PHY_ADDR are silently skipped.
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'h18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_IN,
    output logic        MDIO_IN_EN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        MEM_WR,
    output logic        MEM_RD,
    output logic        FRAME_ERR
);

    logic        rise;
    logic        fall;
    mdio_state_t state_reg;
    mdio_state_t state_next;
    logic [5:0]  k_reg;
    logic [5:0]  k_inc;
    logic [31:0] sr_reg;
    logic [13:0] hdr;
    logic        phy_match;
    logic        start_wr;
    logic        start_rd;
    logic        err_set;
    logic        wr_pend_reg;
    logic        rd_pend_reg;
    logic        rd_load_reg;
    logic [15:0] rd_sh_reg;
    logic        mdio_in_reg;
    logic        mdio_in_en_reg;
    logic [4:0]  addr_reg;
    logic [15:0] wr_data_reg;
    logic        mem_wr_reg;
    logic        mem_rd_reg;
    logic        frame_err_reg;

    mdc_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .mdc   (MDC),
        .rise  (rise),
        .fall  (fall)
    );

    assign k_inc = k_reg + 6'd1;
    // The header as it will stand once the bit on this rise is shifted in
    assign hdr   = {sr_reg[12:0], MDIO_OUT};

`ifdef MDIO_PHYAD_FILTER_EN
    logic unused_bits;
    assign phy_match   = (hdr[9:5] == PHY_ADDR);
    assign unused_bits = sr_reg[31];
`else
    logic unused_bits;
    assign phy_match   = 1'b1;
    assign unused_bits = ^{PHY_ADDR, hdr[9:5], sr_reg[31]};
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and one-cycle action requests
    always_comb begin
        state_next = state_reg;
        start_wr   = 1'b0;
        start_rd   = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise && MDIO_OE) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (rise) begin
                    if (!MDIO_OE) begin
                        state_next = IDLE;
                    end else if (k_inc == HDR_END) begin
                        if (!phy_match) begin
                            state_next = SKIP;
                        end else if (!header_valid(hdr)) begin
                            state_next = SKIP;
                            err_set    = 1'b1;
                        end else if (hdr[11:10] == OP_WRITE) begin
                            state_next = WR;
                        end else begin
                            state_next = RD;
                            start_rd   = 1'b1;
                        end
                    end
                end
            end
            WR: begin
                if (rise && (k_inc == FRAME_END)) begin
                    state_next = IDLE;
                    start_wr   = 1'b1;
                end
            end
            RD: begin
                if (fall && (k_reg == FRAME_END)) begin
                    state_next = IDLE;
                end
            end
            SKIP: begin
                if (rise && (k_inc == FRAME_END)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit counter and input shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg  <= '0;
            sr_reg <= '0;
        end else begin
            if (state_next == IDLE) begin
                k_reg <= '0;
            end else if (rise) begin
                k_reg <= k_inc;
            end
            if (rise && MDIO_OE) begin
                sr_reg <= {sr_reg[30:0], MDIO_OUT};
            end
        end
    end

    // Memory strobes, address/data capture and error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_reg   <= 1'b0;
            rd_pend_reg   <= 1'b0;
            rd_load_reg   <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_rd_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            addr_reg      <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_pend_reg   <= start_wr;
            rd_pend_reg   <= start_rd;
            frame_err_reg <= err_set;
            mem_wr_reg    <= wr_pend_reg;
            mem_rd_reg    <= rd_pend_reg;
            // Memory answers one clk after MEM_RD, so load one clk later still
            rd_load_reg   <= mem_rd_reg;
            // No MDC rise can land in the cycle after a sample, so sr_reg is stable here
            if (wr_pend_reg) begin
                addr_reg    <= sr_reg[22:18];
                wr_data_reg <= sr_reg[15:0];
            end else if (rd_pend_reg) begin
                addr_reg <= sr_reg[4:0];
            end
        end
    end

    // Read-data serialiser: TA zero, then D15..D0 on successive MDC falls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sh_reg      <= '0;
            mdio_in_reg    <= 1'b0;
            mdio_in_en_reg <= 1'b0;
        end else begin
            if (rd_load_reg) begin
                rd_sh_reg <= RD_DATA;
            end else if ((state_reg == RD) && fall) begin
                if (k_reg == (TA_END - 6'd1)) begin
                    mdio_in_en_reg <= 1'b1;
                    mdio_in_reg    <= 1'b0;
                end else if ((k_reg >= TA_END) && (k_reg < FRAME_END)) begin
                    mdio_in_reg <= rd_sh_reg[15];
                    rd_sh_reg   <= {rd_sh_reg[14:0], 1'b0};
                end else if (k_reg == FRAME_END) begin
                    mdio_in_en_reg <= 1'b0;
                    mdio_in_reg    <= 1'b0;
                end
            end
        end
    end

    assign MDIO_IN    = mdio_in_reg;
    assign MDIO_IN_EN = mdio_in_en_reg;
    assign ADDR       = addr_reg;
    assign WR_DATA    = wr_data_reg;
    assign MEM_WR     = mem_wr_reg;
    assign MEM_RD     = mem_rd_reg;
    assign FRAME_ERR  = frame_err_reg;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Self-checking bench for mdio_peripheral: a table of frames plus
// hand-written abort, back-to-back and reset-mid-read sequences. Memory
// events are checked against a scoreboard queue of expected events.
`timescale 1ns/1ps
module tb_mdio_peripheral;

    localparam int K_NONE = -1;
    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_ERR  = 2;
    localparam int NVEC   = 9;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] frame;
        int          oe_until;
        int          kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MDC = 1'b0;
    logic        MDIO_OUT = 1'b0;
    logic        MDIO_OE = 1'b0;
    logic [15:0] RD_DATA;
    logic        MDIO_IN;
    logic        MDIO_IN_EN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        MEM_WR;
    logic        MEM_RD;
    logic        FRAME_ERR;

    logic [15:0] mem [32];
    ev_t         exp_q [$];
    vec_t        vecs [NVEC];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mdio_peripheral #(.PHY_ADDR(5'h18)) dut (
        .clk        (clk),
        .reset      (reset),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .RD_DATA    (RD_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDIO_IN_EN (MDIO_IN_EN),
        .ADDR       (ADDR),
        .WR_DATA    (WR_DATA),
        .MEM_WR     (MEM_WR),
        .MEM_RD     (MEM_RD),
        .FRAME_ERR  (FRAME_ERR)
    );

    // Register memory model with registered read
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
            mem[12] <= 16'hF5B5;
            RD_DATA <= 16'h0000;
        end else begin
            if (MEM_WR) mem[ADDR] <= WR_DATA;
            if (MEM_RD) RD_DATA <= mem[ADDR];
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] rg,
                                       input logic [15:0] d);
        return {st, op, phy, rg, 2'b10, d};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [4:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [4:0] a, input logic [15:0] d);
        ev_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != a || (kind == K_WR && e.data != d)) begin
                errors = errors + 1;
                $display("FAIL event actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic check_q_empty(input string name);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s missing_events actual %0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (MEM_WR)    observe(K_WR, ADDR, WR_DATA);
                if (MEM_RD)    observe(K_RD, ADDR, 16'h0000);
                if (FRAME_ERR) observe(K_ERR, 5'h00, 16'h0000);
            end
        end
    endtask

    // Drive bits 1..last_bit (MDC low 2 clk, high 2 clk) and collect MDIO_IN
    task automatic send_frame(input logic [31:0] f, input int oe_until, input int last_bit,
                              input bit drive, output logic [15:0] rx, output logic ta,
                              output int en_bad);
        rx = 16'h0000;
        ta = 1'b1;
        en_bad = 0;
        for (int k = 1; k <= last_bit; k++) begin
            @(negedge clk);
            MDIO_OE  = (k <= oe_until);
            MDIO_OUT = (k <= oe_until) ? f[32-k] : 1'b0;
            if (k >= 16) begin
                if (MDIO_IN_EN !== drive) en_bad++;
            end else if (MDIO_IN_EN !== 1'b0) begin
                en_bad++;
            end
            if (k == 16) ta = MDIO_IN;
            if (k >= 17) rx[32-k] = MDIO_IN;
            @(negedge clk);
            MDC = 1'b1;
            @(negedge clk);
            @(negedge clk);
            MDC = 1'b0;
        end
        if (last_bit == 32) begin
            @(negedge clk);
            if (MDIO_IN_EN !== 1'b0 || MDIO_IN !== 1'b0) en_bad++;
        end
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b0;
    endtask

    initial begin
        logic [15:0] rx;
        logic        ta;
        int          en_bad;

        vecs[0] = '{32'h5C6AF5B5, 32, K_WR, 5'h1A, 16'hF5B5};
        vecs[2] = '{32'h9C78402B, 32, K_ERR, 5'h00, 16'h0000};
        vecs[3] = '{32'h5C6AF5B5, 32, K_WR, 5'h1A, 16'hF5B5};
        vecs[4] = '{mk(2'b01, 2'b01, 5'h18, 5'h03, 16'h1234), 32, K_WR, 5'h03, 16'h1234};
        vecs[5] = '{mk(2'b01, 2'b10, 5'h18, 5'h03, 16'h0000), 14, K_RD, 5'h03, 16'h1234};
        vecs[6] = '{mk(2'b01, 2'b11, 5'h18, 5'h04, 16'h5555), 32, K_ERR, 5'h00, 16'h0000};
        vecs[7] = '{mk(2'b01, 2'b00, 5'h18, 5'h04, 16'hAAAA), 32, K_ERR, 5'h00, 16'h0000};
`ifdef MDIO_PHYAD_FILTER_EN
        vecs[1] = '{32'h6FB246C4, 14, K_NONE, 5'h00, 16'h0000};
        vecs[8] = '{mk(2'b01, 2'b01, 5'h1F, 5'h07, 16'hCAFE), 32, K_NONE, 5'h00, 16'h0000};
`else
        vecs[1] = '{32'h6FB246C4, 14, K_RD, 5'h0C, 16'hF5B5};
        vecs[8] = '{mk(2'b01, 2'b01, 5'h1F, 5'h07, 16'hCAFE), 32, K_WR, 5'h07, 16'hCAFE};
`endif

        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {6'd0, MDIO_IN_EN, MDIO_IN, MEM_WR, MEM_RD, FRAME_ERR, ADDR, WR_DATA}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table of frames
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].kind != K_NONE) expect_ev(vecs[i].kind, vecs[i].addr, vecs[i].data);
            send_frame(vecs[i].frame, vecs[i].oe_until, 32, vecs[i].kind == K_RD, rx, ta, en_bad);
            repeat (6) @(negedge clk);
            $display("vec %0d frame %h kind %0d rx %h", i, vecs[i].frame, vecs[i].kind, rx);
            check_q_empty($sformatf("vec%0d_events", i));
            check_val($sformatf("vec%0d_drive", i), en_bad, 32'd0);
            if (vecs[i].kind == K_RD) begin
                check_val($sformatf("vec%0d_ta", i), {31'd0, ta}, 32'd0);
                check_val($sformatf("vec%0d_rdata", i), {16'd0, rx}, {16'd0, vecs[i].data});
            end
        end

        // Abort at k=8, then a frame immediately after
        expect_ev(K_WR, 5'h05, 16'hBEEF);
        send_frame(32'h5C6AF5B5, 7, 8, 1'b0, rx, ta, en_bad);
        send_frame(mk(2'b01, 2'b01, 5'h18, 5'h05, 16'hBEEF), 32, 32, 1'b0, rx, ta, en_bad);
        repeat (6) @(negedge clk);
        $display("abort_then_write addr 05 data beef");
        check_q_empty("abort_events");
        check_val("abort_drive", en_bad, 32'd0);

        // Back-to-back writes with no idle gap
        expect_ev(K_WR, 5'h09, 16'h0F0F);
        expect_ev(K_WR, 5'h0A, 16'hF00D);
        send_frame(mk(2'b01, 2'b01, 5'h18, 5'h09, 16'h0F0F), 32, 32, 1'b0, rx, ta, en_bad);
        send_frame(mk(2'b01, 2'b01, 5'h18, 5'h0A, 16'hF00D), 32, 32, 1'b0, rx, ta, en_bad);
        repeat (6) @(negedge clk);
        $display("back_to_back writes 09 and 0a");
        check_q_empty("b2b_events");

        // Reset asserted mid-read at k=20
        expect_ev(K_RD, 5'h0C, 16'h0000);
        send_frame(mk(2'b01, 2'b10, 5'h18, 5'h0C, 16'h0000), 14, 20, 1'b1, rx, ta, en_bad);
        @(negedge clk);
        check_val("midrd_drive_before", {31'd0, MDIO_IN_EN}, 32'd1);
        check_val("midrd_drive_bits", en_bad, 32'd0);
        check_q_empty("midrd_events");
        #2 reset = 1'b1;
        #1 check_val("midrd_reset_outputs",
                     {6'd0, MDIO_IN_EN, MDIO_IN, MEM_WR, MEM_RD, FRAME_ERR, ADDR, WR_DATA}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset_mid_read k=20");

        // Decoding resumes normally after the reset
        expect_ev(K_RD, 5'h0C, 16'hF5B5);
        send_frame(mk(2'b01, 2'b10, 5'h18, 5'h0C, 16'h0000), 14, 32, 1'b1, rx, ta, en_bad);
        repeat (6) @(negedge clk);
        $display("post_reset read addr 0c rx %h", rx);
        check_q_empty("post_reset_events");
        check_val("post_reset_drive", en_bad, 32'd0);
        check_val("post_reset_ta", {31'd0, ta}, 32'd0);
        check_val("post_reset_rdata", {16'd0, rx}, 32'h0000F5B5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
